// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Program-counter stage for the MIPS fetch path. Owns next-PC selection:
// sequential increment, branch/jump redirect, exception vector, stall hold,
// halt/resume, misaligned-target trapping and a fetch-valid qualifier.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   stall        in   hold pc and fetch_valid (hazard unit)
//   halt         in   enter HALT at the next edge
//   resume       in   leave HALT at the next edge
//   exc          in   exception redirect to EXC_VEC
//   br_taken     in   branch redirect request
//   br_target    in   branch target [ADDR_W]
//   jmp          in   jump redirect request
//   jmp_target   in   jump target [ADDR_W]
//   pc           out  current fetch PC [ADDR_W]
//   pc_inc       out  pc + INC (combinational, wraps mod 2^ADDR_W)
//   fetch_valid  out  pc is a real fetch; low means bubble
//   redirect     out  registered pulse: pc came from a non-sequential source
//   misalign_err out  registered pulse: redirect target was not INC-aligned
//
// Optional feature macro FETCH_PERF_EN adds:
//   fetch_cnt    out  [31:0] edges with fetch_valid=1 and stall=0
//   redir_cnt    out  [31:0] edges that set redirect
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0080,
    parameter int          INC       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    input  logic              exc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc,
    output logic              fetch_valid,
    output logic              redirect,
    output logic              misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       redir_cnt
`endif
);

    localparam logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC     = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] INC_W      = ADDR_W'(INC);
    // Low address bits that must be zero for an aligned target. With INC=1
    // the mask is empty, which disables the alignment check entirely.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;

    logic br_misaligned;
    logic jmp_misaligned;

    assign pc_inc         = pc_q + INC_W;
    assign br_misaligned  = |(br_target & ALIGN_MASK);
    assign jmp_misaligned = |(jmp_target & ALIGN_MASK);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        redirect_d    = 1'b0;
        misalign_d    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Single bubble cycle, then the reset PC becomes a real fetch.
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end

            ST_RUN: begin
                if (exc) begin
                    pc_d          = EXC_PC;
                    redirect_d    = 1'b1;
                    fetch_valid_d = 1'b1;
                end else if (br_taken) begin
                    redirect_d    = 1'b1;
                    fetch_valid_d = 1'b1;
                    if (br_misaligned) begin
                        pc_d       = EXC_PC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = br_target;
                    end
                end else if (jmp) begin
                    redirect_d    = 1'b1;
                    fetch_valid_d = 1'b1;
                    if (jmp_misaligned) begin
                        pc_d       = EXC_PC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = jmp_target;
                    end
                end else if (halt) begin
                    state_d       = ST_HALT;
                    fetch_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d          = pc_inc;
                    fetch_valid_d = 1'b1;
                end
                // stall alone: pc, fetch_valid and state keep their values.
            end

            ST_HALT: begin
                fetch_valid_d = 1'b0;
                if (exc) begin
                    state_d       = ST_RUN;
                    pc_d          = EXC_PC;
                    redirect_d    = 1'b1;
                    fetch_valid_d = 1'b1;
                end else if (resume) begin
                    // Resume wins over a simultaneous halt; refetch held pc.
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                end
            end

            default: begin
                state_d       = ST_BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            redirect_q    <= redirect_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign fetch_valid  = fetch_valid_q;
    assign redirect     = redirect_q;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redir_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            redir_cnt_q <= 32'd0;
        end else begin
            if (fetch_valid_q && !stall) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redirect_d) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, halt, resume, exc, br_taken, jmp;
    logic [31:0] br_target, jmp_target;
    logic [31:0] pc, pc_inc;
    logic        fetch_valid, redirect, misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, redir_cnt;
`endif

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .ADDR_W   (32),
        .RESET_VEC(32'h0000_0000),
        .EXC_VEC  (32'h0000_0080),
        .INC      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .resume      (resume),
        .exc         (exc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .fetch_valid (fetch_valid),
        .redirect    (redirect),
        .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .redir_cnt   (redir_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_inc;
        logic        fv;
        logic        red;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Input bit order for step(): {rst, stall, halt, resume, exc, br, jmp}
    localparam logic [6:0] I_NONE   = 7'b0000000;
    localparam logic [6:0] I_RST    = 7'b1000000;
    localparam logic [6:0] I_STALL  = 7'b0100000;
    localparam logic [6:0] I_HALT   = 7'b0010000;
    localparam logic [6:0] I_RESUME = 7'b0001000;
    localparam logic [6:0] I_EXC    = 7'b0000100;
    localparam logic [6:0] I_BR     = 7'b0000010;
    localparam logic [6:0] I_JMP    = 7'b0000001;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [6:0] in, input logic [31:0] bt,
                        input logic [31:0] jt, input logic [31:0] e_pc,
                        input logic e_fv, input logic e_red, input logic e_mis);
        exp_t e;
        @(negedge clk);
        {rst, stall, halt, resume, exc, br_taken, jmp} = in;
        br_target  = bt;
        jmp_target = jt;
        e.pc     = e_pc;
        e.pc_inc = e_pc + 32'd4;
        e.fv     = e_fv;
        e.red    = e_red;
        e.mis    = e_mis;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: sample a little after each active edge and compare.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_txn++;
            if (pc !== e.pc || pc_inc !== e.pc_inc || fetch_valid !== e.fv ||
                redirect !== e.red || misalign_err !== e.mis) begin
                n_bad++;
                $display("FAIL txn%0d: got pc=%h inc=%h fv=%b red=%b mis=%b, need pc=%h inc=%h fv=%b red=%b mis=%b",
                         n_txn, pc, pc_inc, fetch_valid, redirect, misalign_err,
                         e.pc, e.pc_inc, e.fv, e.red, e.mis);
            end else begin
                $display("txn%0d: pc=%h fv=%b red=%b mis=%b ok",
                         n_txn, pc, fetch_valid, redirect, misalign_err);
            end
        end
    end

    initial begin
        {rst, stall, halt, resume, exc, br_taken, jmp} = I_NONE;
        br_target  = 32'h0;
        jmp_target = 32'h0;

        // 1. Reset and boot
        step(I_RST,  0, 0, 32'h0, 0, 0, 0);
        step(I_RST,  0, 0, 32'h0, 0, 0, 0);
        step(I_NONE, 0, 0, 32'h0, 1, 0, 0);   // BOOT -> RUN, reset PC valid
        step(I_NONE, 0, 0, 32'h4, 1, 0, 0);
        step(I_NONE, 0, 0, 32'h8, 1, 0, 0);
        step(I_NONE, 0, 0, 32'hC, 1, 0, 0);
        step(I_NONE, 0, 0, 32'h10, 1, 0, 0);

        // 2. Branch under stall, then stall alone holds
        step(I_STALL | I_BR, 32'h0000_FC00, 0, 32'h0000_FC00, 1, 1, 0);
        step(I_STALL, 0, 0, 32'h0000_FC00, 1, 0, 0);
        step(I_STALL, 0, 0, 32'h0000_FC00, 1, 0, 0);

        // 3. Priority and alignment
        step(I_EXC | I_BR | I_JMP, 32'h100, 32'h200, 32'h80, 1, 1, 0);
        step(I_BR, 32'h7800_FC02, 0, 32'h80, 1, 1, 1);
        step(I_NONE, 0, 0, 32'h84, 1, 0, 0);
        step(I_BR | I_JMP, 32'h300, 32'h400, 32'h300, 1, 1, 0);  // branch wins
        step(I_JMP, 0, 32'h401, 32'h80, 1, 1, 1);                // misaligned jump
        step(I_BR | I_JMP, 32'h302, 32'h400, 32'h80, 1, 1, 1);   // bad branch still wins

        // 4. Wrap-around
        step(I_JMP, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1, 0);
        step(I_NONE, 0, 0, 32'h0, 1, 0, 0);
        step(I_NONE, 0, 0, 32'h4, 1, 0, 0);

        // 5. Halt / resume
        step(I_JMP, 0, 32'h20, 32'h20, 1, 1, 0);
        step(I_HALT, 0, 0, 32'h20, 0, 0, 0);
        step(I_BR, 32'h500, 0, 32'h20, 0, 0, 0);
        step(I_BR | I_STALL, 32'h500, 0, 32'h20, 0, 0, 0);
        step(I_BR | I_JMP, 32'h500, 32'h600, 32'h20, 0, 0, 0);
        step(I_RESUME, 0, 0, 32'h20, 1, 0, 0);
        step(I_NONE, 0, 0, 32'h24, 1, 0, 0);
        step(I_HALT, 0, 0, 32'h24, 0, 0, 0);
        step(I_HALT | I_RESUME, 0, 0, 32'h24, 1, 0, 0);          // resume wins
        step(I_HALT, 0, 0, 32'h24, 0, 0, 0);
        step(I_EXC | I_RESUME, 0, 0, 32'h80, 1, 1, 0);          // exc from HALT

        // 6. Mid-operation reset while halted with exc pending
        step(I_HALT, 0, 0, 32'h80, 0, 0, 0);
        step(I_RST | I_EXC, 0, 0, 32'h0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        #3;
        n_cmp++;
        if (fetch_cnt !== 32'd0 || redir_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_reset: got fetch_cnt=%0d redir_cnt=%0d, need 0 and 0",
                     fetch_cnt, redir_cnt);
        end else begin
            $display("perf_reset: counters 0 ok");
        end
`endif
        step(I_NONE, 0, 0, 32'h0, 1, 0, 0);
        step(I_NONE, 0, 0, 32'h4, 1, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #4;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected transactions never observed, need 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
